// File: rtl/cla_pipe_addsub_pkg.sv
// rtl/cla_pipe_addsub_pkg.sv - shared helpers for the pipelined CLA adder/subtractor
//
// Purpose: elaboration-time helpers shared by the adder pipeline.
//   seg_count(width, seg) : number of SEG-bit segments in a WIDTH-bit operand,
//                           which is also the pipeline depth.
package cla_pipe_addsub_pkg;

    function automatic int seg_count(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/cla_seg.sv
// rtl/cla_seg.sv - combinational SEG-bit carry-lookahead segment
//
// Purpose: adds two SEG-bit segments plus a carry-in using flattened
//          generate/propagate lookahead (no ripple between bit positions).
// Ports:
//   a, b      in  SEG  segment operands
//   ci        in  1    carry into bit 0
//   s         out SEG  segment sum
//   co        out 1    carry out of the segment MSB
//   c_msb_in  out 1    carry into the segment MSB (for signed overflow)
module cla_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]ci
    // pp accumulates the running product of propagates from bit i downward.
    always_comb begin
        logic pp;
        c    = '0;
        pp   = 1'b0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
    end

    assign s        = p ^ c[SEG-1:0];
    assign co       = c[SEG];
    assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready
//
// Purpose: WIDTH-bit a+b+ci or a-b, one SEG-bit segment per stage, segment
//          carry registered between stages. Latency STAGES = WIDTH/SEG cycles.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input handshake (in_ready = ~out_valid | out_ready)
//   a, b, ci, sub        operands, carry-in (add only), subtract select
//   out_valid, out_ready output handshake
//   s, co, ovf           result, carry out of MSB, signed overflow
module cla_pipe_addsub
    import cla_pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = seg_count(WIDTH, SEG);

    if (WIDTH % SEG != 0) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             seg_cm [STAGES];

    // The whole pipe moves as one: either every stage shifts or none does.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = (k + 1) * SEG;

        logic           vld_d;
        logic           c_d;
        logic           vld_q;
        logic           cy_q;
        logic           seg_co;
        logic [SEG-1:0] sa;
        logic [SEG-1:0] sb;
        logic [SEG-1:0] seg_s;
        logic [SW-1:0]  sum_d;
        logic [SW-1:0]  sum_q;

        if (k == 0) begin : g_src
            assign vld_d = in_valid;
            assign c_d   = c0;
            assign sa    = a[SEG-1:0];
            assign sb    = b_eff[SEG-1:0];
            assign sum_d = seg_s;
        end else begin : g_src
            assign vld_d = g_stage[k-1].vld_q;
            assign c_d   = g_stage[k-1].cy_q;
            assign sa    = g_stage[k-1].g_fwd.ra_q[SEG-1:0];
            assign sb    = g_stage[k-1].g_fwd.rb_q[SEG-1:0];
            // New segment lands above the low bits already completed.
            assign sum_d = {seg_s, g_stage[k-1].sum_q};
        end

        cla_seg #(
            .SEG(SEG)
        ) u_seg (
            .a        (sa),
            .b        (sb),
            .ci       (c_d),
            .s        (seg_s),
            .co       (seg_co),
            .c_msb_in (seg_cm[k])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
                cy_q  <= seg_co;
                sum_q <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Only the operand segments still to be added travel forward.
            localparam int RW = WIDTH - SW;

            logic [RW-1:0] ra_d;
            logic [RW-1:0] rb_d;
            logic [RW-1:0] ra_q;
            logic [RW-1:0] rb_q;

            if (k == 0) begin : g_rem
                assign ra_d = a[WIDTH-1:SEG];
                assign rb_d = b_eff[WIDTH-1:SEG];
            end else begin : g_rem
                assign ra_d = g_stage[k-1].g_fwd.ra_q[RW+SEG-1:SEG];
                assign rb_d = g_stage[k-1].g_fwd.rb_q[RW+SEG-1:SEG];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (adv) begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end
        end else begin : g_last
            // Carry into the MSB, kept for the overflow flag.
            logic cm_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cm_q <= 1'b0;
                end else if (adv) begin
                    cm_q <= seg_cm[k];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign s         = g_stage[STAGES-1].sum_q;
    assign co        = g_stage[STAGES-1].cy_q;
    assign ovf       = g_stage[STAGES-1].cy_q ^ g_stage[STAGES-1].g_last.cm_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - self-checking bench for cla_pipe_addsub
module tb_cla_pipe_addsub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, ci16, sub16, ov16, or16, co16, ovf16;
    logic [15:0] a16, b16, s16;
    logic        iv8, ir8, ci8, sub8, ov8, or8, co8, ovf8;
    logic [7:0]  a8, b8, s8;

    cla_pipe_addsub #(.WIDTH(16), .SEG(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .ci(ci16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .s(s16), .co(co16), .ovf(ovf16)
    );

    cla_pipe_addsub #(.WIDTH(8), .SEG(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .ci(ci8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .s(s8), .co(co8), .ovf(ovf8)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        res_t        exp;
    } vec_t;

    res_t        q16[$];
    res_t        q8[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_stall16 = 1'b0;
    logic [15:0] prev_s16 = '0;
    logic        done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sub);
        longint unsigned mask, aa, bb, sum;
        res_t r;
        mask  = (64'd1 << w) - 64'd1;
        aa    = {48'd0, a} & mask;
        bb    = (sub ? {48'd0, ~b} : {48'd0, b}) & mask;
        sum   = aa + bb + (sub ? 64'd1 : {63'd0, ci});
        r.s   = 16'(sum & mask);
        r.co  = sum[w];
        r.ovf = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
        return r;
    endfunction

    // Drive one operation at posedge+1; returns one cycle after acceptance, at posedge+1.
    task automatic drive(input bit sel8, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sub, input res_t e);
        int n = 0;
        if (sel8) begin a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; sub8 = sub; iv8 = 1'b1; end
        else      begin a16 = a; b16 = b; ci16 = ci; sub16 = sub; iv16 = 1'b1; end
        @(negedge clk);
        while (!(sel8 ? ir8 : ir16) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(sel8 ? ir8 : ir16)) chk("in_ready_timeout", 32'(sel8 ? ir8 : ir16), 32'd1);
        else if (sel8) q8.push_back(e);
        else q16.push_back(e);
        @(posedge clk);
        #1;
        if (sel8) iv8 = 1'b0; else iv16 = 1'b0;
    endtask

    task automatic latency(input bit sel8, input int expc, input string name);
        int c = 1;
        while (!(sel8 ? ov8 : ov16) && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(name, 32'(c), 32'(expc));
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(q16.size() + q8.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall16 = 1'b0;
        end else begin
            if (prev_stall16) begin
                chk("hold_valid16", 32'(ov16), 32'd1);
                chk("hold_s16", 32'(s16), 32'(prev_s16));
            end
            chk("in_ready_rule16", 32'(ir16), 32'(!(ov16 && !or16)));
            if (ov16 && or16) begin
                chk("queue_nonempty16", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    res_t e;
                    e = q16.pop_front();
                    chk("res16", 32'({s16, co16, ovf16}), 32'(e));
                end
            end
            prev_stall16 = ov16 && !or16;
            prev_s16     = s16;
            if (ov8 && or8) begin
                chk("queue_nonempty8", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    res_t e;
                    e = q8.pop_front();
                    chk("res8", 32'({8'h00, s8, co8, ovf8}), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        vec_t        tbl[7];
        time         t0;
        logic [15:0] ra, rb;
        logic        rc, rs;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        tbl[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0}};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        tbl[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};

        rst = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
        iv8 = 1'b0;  a8 = '0;  b8 = '0;  ci8 = 1'b0;  sub8 = 1'b0;  or8 = 1'b1;
        done = 1'b0;

        #12;
        chk("reset_out_valid16", 32'(ov16), 32'd0);
        chk("reset_s16", 32'(s16), 32'd0);
        chk("reset_co_ovf16", 32'({co16, ovf16}), 32'd0);
        chk("reset_in_ready16", 32'(ir16), 32'd1);
        chk("reset_out_valid8", 32'(ov8), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready16", 32'(ir16), 32'd1);

        drive(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0});
        latency(1'b0, 4, "latency16");
        drain();

        for (int i = 0; i < 7; i++)
            drive(1'b0, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, tbl[i].exp);
        drain();

        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = 16'($urandom); rb = 16'($urandom);
                    rc = 1'($urandom); rs = 1'($urandom);
                    drive(1'b0, ra, rb, rc, rs, model(16, ra, rb, rc, rs));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    or16 = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        or16 = 1'b1;
        drain();

        // Reset with three operations in flight, the oldest already at the output.
        @(posedge clk);
        #1;
        drive(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, '{16'h3333, 1'b0, 1'b0});
        drive(1'b0, 16'h4444, 16'h1111, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0});
        drive(1'b0, 16'h0100, 16'h0001, 1'b0, 1'b1, '{16'h00FF, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        chk("pre_reset_valid16", 32'(ov16), 32'd1);
        #1 rst = 1'b1;
        q16.delete();
        #1;
        chk("async_reset_valid16", 32'(ov16), 32'd0);
        chk("async_reset_s16", 32'({s16, co16, ovf16}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale16", 32'(ov16), 32'd0);
        end
        drive(1'b0, 16'h0003, 16'h0004, 1'b1, 1'b0, '{16'h0008, 1'b0, 1'b0});
        latency(1'b0, 4, "latency_after_reset16");
        drain();

        drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0});
        latency(1'b1, 1, "latency8");
        drain();
        drive(1'b1, 16'h0080, 16'h0001, 1'b0, 1'b1, '{16'h007F, 1'b1, 1'b1});
        drain();
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom); rs = 1'($urandom);
            drive(1'b1, ra, rb, rc, rs, model(8, ra, rb, rc, rs));
        end
        chk("throughput8", 32'($time - t0), 32'd80);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
